// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - regfile write-port arbiter with in-order writeback FIFO and pending scoreboard
module rf_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  input  logic [AW-1:0]             chk_rs1,
  input  logic [AW-1:0]             chk_rs2,
  input  logic [AW-1:0]             chk_rd,
  output logic                      chk_busy,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [AW-1:0]             alu_rd,
  input  logic [DW-1:0]             alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [AW-1:0]             mem_rd,
  input  logic [DW-1:0]             mem_data,
  output logic                      rf_we,
  output logic [AW-1:0]             rf_waddr,
  output logic [DW-1:0]             rf_wdata,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  // FIFO storage and bookkeeping
  logic [AW-1:0]   fifo_rd   [DEPTH];
  logic [DW-1:0]   fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;

  // handshake / push decode
  logic            mem_acc;
  logic            alu_acc;
  logic            mem_push;
  logic            alu_push;
  logic            pop;
  logic [PW-1:0]   alu_slot;
  logic [PW-1:0]   wr_ptr_nxt;
  logic [CW-1:0]   count_nxt;

  // scoreboard
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Readiness looks only at the registered count, so a pop in the same
  // cycle never creates room; MEM gets the single free slot when both want it.
  always_comb begin
    free      = CW'(DEPTH) - count;
    mem_ready = (free >= CW'(1));
    alu_ready = (free >= CW'(2)) | ((free >= CW'(1)) & ~mem_valid);
  end

  // Accepted results to r0 complete the handshake but never enter the FIFO.
  always_comb begin
    mem_acc    = mem_valid & mem_ready;
    alu_acc    = alu_valid & alu_ready;
    mem_push   = mem_acc & (mem_rd != '0);
    alu_push   = alu_acc & (alu_rd != '0);
    pop        = (count != '0);
    alu_slot   = wr_ptr + PW'(mem_push);
    wr_ptr_nxt = wr_ptr + PW'(mem_push) + PW'(alu_push);
    count_nxt  = count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Pointer and count update; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Entry storage: MEM takes the first free slot, ALU the one after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (mem_push) begin
        fifo_rd[wr_ptr]   <= mem_rd;
        fifo_data[wr_ptr] <= mem_data;
      end
      if (alu_push) begin
        fifo_rd[alu_slot]   <= alu_rd;
        fifo_data[alu_slot] <= alu_data;
      end
    end
  end

  // Write port is driven straight from the head entry, so there is no
  // combinational path from the producer ports to the regfile.
  always_comb begin
    rf_we     = pop;
    rf_waddr  = pop ? fifo_rd[rd_ptr]   : '0;
    rf_wdata  = pop ? fifo_data[rd_ptr] : '0;
    occupancy = count;
  end

  // Pending next-state: commit clears, issue sets, and set wins on a collision.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pending_nxt[iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Decode hazard query against the registered scoreboard.
  always_comb begin
    chk_busy = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb/tb_rf_writeback_unit.sv - scoreboard bench for rf_writeback_unit
module tb_rf_writeback_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic [AW-1:0]     chk_rs1, chk_rs2, chk_rd;
  logic              chk_busy;
  logic              alu_valid, alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [DW-1:0]     alu_data;
  logic              mem_valid, mem_ready;
  logic [AW-1:0]     mem_rd;
  logic [DW-1:0]     mem_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [$clog2(DEPTH):0] occupancy;

  rf_writeback_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .chk_busy(chk_busy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] pend;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_wr  = 0;

  int          m_cnt;
  int          m_free;
  logic        m_mr, m_ar;
  logic [15:0] m_nxt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle, checks this cycle's outputs, then advances.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend = '0;
    end else begin
      m_cnt  = exp_q.size();
      m_free = DEPTH - m_cnt;
      m_mr   = (m_free >= 1);
      m_ar   = (m_free >= 2) || ((m_free >= 1) && !mem_valid);
      check("mem_ready", 64'(mem_ready), 64'(m_mr));
      check("alu_ready", 64'(alu_ready), 64'(m_ar));
      check("occupancy", 64'(occupancy), 64'(m_cnt));
      check("chk_busy", 64'(chk_busy), 64'(pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd]));
      if (m_cnt > 0) begin
        check("rf_we", 64'(rf_we), 64'd1);
        check("rf_waddr", 64'(rf_waddr), 64'(exp_q[0].rd));
        check("rf_wdata", 64'(rf_wdata), 64'(exp_q[0].data));
      end else begin
        check("rf_we_idle", 64'(rf_we), 64'd0);
        check("rf_waddr_idle", 64'(rf_waddr), 64'd0);
        check("rf_wdata_idle", 64'(rf_wdata), 64'd0);
      end
      if (rf_we) n_wr++;
      if (iss_valid && iss_rd != '0) check("iss_not_pending", 64'(pend[iss_rd]), 64'd0);
      m_nxt = pend;
      if (m_cnt > 0) begin
        m_nxt[exp_q[0].rd] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (iss_valid && iss_rd != '0) m_nxt[iss_rd] = 1'b1;
      pend = m_nxt;
      if (mem_valid && m_mr && mem_rd != '0) begin
        exp_q.push_back('{rd: mem_rd, data: mem_data});
        n_acc++;
      end
      if (alu_valid && m_ar && alu_rd != '0) begin
        exp_q.push_back('{rd: alu_rd, data: alu_data});
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    step();
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  // Present ALU and/or MEM results, holding each until its handshake completes.
  task automatic send(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    logic a_pend, m_pend;
    int t;
    a_pend = av;
    m_pend = mv;
    t = 0;
    alu_rd = ard; alu_data = ad;
    mem_rd = mrd; mem_data = md;
    while ((a_pend || m_pend) && t < 50) begin
      alu_valid = a_pend;
      mem_valid = m_pend;
      @(negedge clk);
      if (alu_valid && alu_ready) a_pend = 1'b0;
      if (mem_valid && mem_ready) m_pend = 1'b0;
      step();
      t++;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    if (t >= 50) check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (occupancy != 0 && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    step();
    step();
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_chk_busy", 64'(chk_busy), 64'd0);
    rst_n = 1'b1;
    step();

    // single ALU result to r5
    chk_rs1 = 4'd5;
    issue(4'd5);
    check("t2_busy_issued", 64'(chk_busy), 64'd1);
    send(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0);
    check("t2_we", 64'(rf_we), 64'd1);
    check("t2_waddr", 64'(rf_waddr), 64'd5);
    check("t2_busy_n1", 64'(chk_busy), 64'd1);
    step();
    check("t2_busy_n2", 64'(chk_busy), 64'd0);
    chk_rs1 = '0;

    // dual push: MEM r4 written before ALU r3
    send(1'b1, 4'd3, 32'h11, 1'b1, 4'd4, 32'h22);
    check("t3_first_addr", 64'(rf_waddr), 64'd4);
    check("t3_first_data", 64'(rf_wdata), 64'h22);
    step();
    check("t3_second_addr", 64'(rf_waddr), 64'd3);
    check("t3_second_data", 64'(rf_wdata), 64'h11);
    drain();

    // result to r0 is dropped
    issue(4'd0);
    send(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0);
    check("t5_no_we", 64'(rf_we), 64'd0);
    check("t5_occupancy", 64'(occupancy), 64'd0);
    check("t5_chk_busy_r0", 64'(chk_busy), 64'd0);

    // commit and issue r7 in the same cycle: set wins
    chk_rs1 = 4'd7;
    send(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
    check("t6_commit_r7", 64'(rf_waddr), 64'd7);
    iss_valid = 1'b1; iss_rd = 4'd7;
    step();
    iss_valid = 1'b0; iss_rd = '0;
    check("t6_pending_r7", 64'(chk_busy), 64'd1);
    chk_rs1 = '0;
    step();

    // back-to-back dual pushes exercising backpressure and ordering
    for (int i = 0; i < 8; i++) begin
      send(1'b1, AW'(8 + (i % 7)), 32'hA000_0000 + 32'(i),
           1'b1, AW'(1 + (i % 6)), 32'hB000_0000 + 32'($urandom_range(0, 255)));
    end
    drain();
    step();
    check("t4_none_lost", 64'(n_wr), 64'(n_acc));
    check("t4_model_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-stream with 3 entries queued
    chk_rs1 = 4'd9;
    issue(4'd9);
    send(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h202);
    send(1'b1, 4'd3, 32'h303, 1'b1, 4'd4, 32'h404);
    check("t1_queued", 64'(occupancy), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t1_rst_we", 64'(rf_we), 64'd0);
    check("t1_rst_occ", 64'(occupancy), 64'd0);
    check("t1_rst_busy", 64'(chk_busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t1_after_we", 64'(rf_we), 64'd0);
    check("t1_after_busy", 64'(chk_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
